// File: rtl/cpu_types_pkg.sv
// Purpose: shared CPU-side types for pipeline stages (word type, skid-stage states).
// Latency: n/a (types and pure helpers only).
// Backpressure: n/a.
package cpu_types_pkg;

  // Architectural data word used across the pipeline.
  typedef logic [31:0] word_t;

  // Occupancy of a two-entry skid stage: number of beats currently held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // A stage can take another beat as long as the skid entry is still free.
  function automatic logic stateHasRoom(pipe_state_t s);
    return (s != TWO);
  endfunction

  // Any state other than EMPTY has a head beat on the outputs.
  function automatic logic stateHasHead(pipe_state_t s);
    return (s != EMPTY);
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Purpose: valid/ready beat bundle between an upstream producer, the skid stage and a consumer.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry the stall in each direction.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 128
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_halt;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_halt;

  // Stage side: accepts beats upstream, presents them downstream.
  modport slave (
    input  in_valid,
    input  in_data,
    input  in_halt,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_halt
  );

  // Environment side: drives upstream beats and the downstream ready.
  modport master (
    output in_valid,
    output in_data,
    output in_halt,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_halt
  );

endinterface

// File: rtl/sat_counter.sv
// Purpose: saturating up-counter, sticks at all-ones instead of wrapping.
// Latency: count reflects inc one cycle later.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic atMax;

  assign atMax = (count == {CNT_W{1'b1}});

  // Count requested cycles, holding once every bit is set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (inc && !atMax) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Purpose: two-entry pipeline skid register with flush squash, sticky halt lock and stall counter.
// Latency: 1 cycle from push into an empty stage to out_valid.
// Backpressure: in_ready is registered-only (full or halt-locked), never combinational from out_ready.
module pipe_skid_reg
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  pipe_skid_reg_if.slave    bus,
  input  logic              flush,
  output logic              halt_lock,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t      state;
  pipe_state_t      nextState;

  // Main entry is the head beat shown downstream; skid catches one beat while stalled.
  logic [WIDTH-1:0] mainData;
  logic             mainHalt;
  logic [WIDTH-1:0] skidData;
  logic             skidHalt;
  logic             haltLock;

  logic             push;
  logic             pop;
  logic             loadMainIn;
  logic             loadSkidIn;
  logic             moveSkid;
  logic             stallInc;

  // Ready depends on registered state only, so out_ready never ripples upstream.
  assign bus.in_ready  = stateHasRoom(state) & ~haltLock;
  assign bus.out_valid = stateHasHead(state);
  assign bus.out_data  = mainData;
  assign bus.out_halt  = mainHalt;
  assign halt_lock     = haltLock;

  assign push     = bus.in_valid & bus.in_ready;
  assign pop      = bus.out_valid & bus.out_ready;
  assign stallInc = bus.out_valid & ~bus.out_ready;

  // Occupancy register; reset and flush both empty the stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // Next occupancy and entry moves; flush discards everything, including a same-cycle push.
  always_comb begin
    nextState  = state;
    loadMainIn = 1'b0;
    loadSkidIn = 1'b0;
    moveSkid   = 1'b0;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            nextState  = ONE;
            loadMainIn = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            nextState  = TWO;
            loadSkidIn = 1'b1;
          end else if (pop && !push) begin
            nextState = EMPTY;
          end else if (push && pop) begin
            // Head leaves and the new beat takes its place in the same cycle.
            loadMainIn = 1'b1;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            nextState = ONE;
            moveSkid  = 1'b1;
          end
        end
        default: begin
          nextState = EMPTY;
        end
      endcase
    end
  end

  // Head entry: cleared on reset so idle outputs read as zero; otherwise held while stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mainData <= '0;
      mainHalt <= 1'b0;
    end else if (loadMainIn) begin
      mainData <= bus.in_data;
      mainHalt <= bus.in_halt;
    end else if (moveSkid) begin
      mainData <= skidData;
      mainHalt <= skidHalt;
    end
  end

  // Skid entry: only meaningful in TWO, so its contents need no reset.
  always_ff @(posedge CLK) begin
    if (loadSkidIn) begin
      skidData <= bus.in_data;
      skidHalt <= bus.in_halt;
    end
  end

  // Once a halt beat is accepted the input stays closed until reset or a squash.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      haltLock <= 1'b0;
    end else if (push && bus.in_halt) begin
      haltLock <= 1'b1;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stallCounter (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stallInc),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Purpose: self-checking bench for pipe_skid_reg against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_skid_reg;

  localparam int W        = 128;
  localparam int STALL_MAX = 65535;

  typedef struct packed {
    logic [W-1:0] d;
    logic         h;
  } beat_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0;
  logic        haltLock;
  logic [15:0] stallCnt;

  logic        flushS = 1'b0;
  logic        haltLockS;
  logic [3:0]  stallCntS;

  int total = 0;
  int bad   = 0;

  // Reference model of the main DUT: held beats in order, lock flag, stall count.
  beat_t q[$];
  bit    mLock  = 1'b0;
  int    mStall = 0;

  pipe_skid_reg_if #(.WIDTH(W)) bus ();
  pipe_skid_reg_if #(.WIDTH(W)) busS ();

  pipe_skid_reg #(.WIDTH(W), .CNT_W(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .flush     (flush),
    .halt_lock (haltLock),
    .stall_cnt (stallCnt)
  );

  pipe_skid_reg #(.WIDTH(W), .CNT_W(4)) dutSat (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (busS),
    .flush     (flushS),
    .halt_lock (haltLockS),
    .stall_cnt (stallCntS)
  );

  always #5 CLK = ~CLK;

  function automatic bit mRdy();
    return (q.size() < 2) && !mLock;
  endfunction

  function automatic bit mVld();
    return (q.size() > 0);
  endfunction

  // Advance one clock, updating the model from the inputs currently driven.
  task automatic tick();
    bit    pu;
    bit    po;
    beat_t b;
    pu = bus.in_valid && mRdy();
    po = mVld() && bus.out_ready;
    if (RST) begin
      q.delete();
      mLock  = 1'b0;
      mStall = 0;
    end else begin
      if (mVld() && !bus.out_ready && mStall < STALL_MAX) mStall++;
      if (flush) begin
        q.delete();
        mLock = 1'b0;
      end else begin
        if (po) b = q.pop_front();
        if (pu) begin
          b.d = bus.in_data;
          b.h = bus.in_halt;
          q.push_back(b);
          if (bus.in_halt) mLock = 1'b1;
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    total++; if (haltLock !== 1'b0) begin bad++; $display("FAIL reset_halt_lock got=%0b exp=0", haltLock); end
    total++; if (stallCnt !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stallCnt); end
    total++; if (bus.out_halt !== 1'b0) begin bad++; $display("FAIL reset_out_halt got=%0b exp=0", bus.out_halt); end
    total++; if (bus.out_data !== {W{1'b0}}) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
    total++; if (stallCntS !== 4'd0) begin bad++; $display("FAIL reset_sat_stall_cnt got=%0d exp=0", stallCntS); end
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_halt  = 1'b0;
      bus.in_data  = W'(i);
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== W'(i)) begin bad++; $display("FAIL stream_beat%0d got vld=%0b data=%0h exp vld=1 data=%0h", i, bus.out_valid, bus.out_data, i); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready%0d got=%0b exp=1", i, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0b exp=0", bus.out_valid); end
  endtask

  task automatic test_skid_fill();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = W'(32'hA);
    tick();
    bus.in_data   = W'(32'hB);
    tick();
    bus.in_valid  = 1'b0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL skid_full_in_ready got=%0b exp=0", bus.in_ready); end
    total++; if (bus.out_data !== W'(32'hA)) begin bad++; $display("FAIL skid_head got=%0h exp=a", bus.out_data); end
    total++; if (stallCnt !== 16'd1) begin bad++; $display("FAIL skid_stall1 got=%0d exp=1", stallCnt); end
    tick();
    total++; if (stallCnt !== 16'd2) begin bad++; $display("FAIL skid_stall2 got=%0d exp=2", stallCnt); end
    total++; if (bus.out_data !== W'(32'hA)) begin bad++; $display("FAIL skid_head_stable got=%0h exp=a", bus.out_data); end
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== W'(32'hB)) begin bad++; $display("FAIL skid_second got vld=%0b data=%0h exp vld=1 data=b", bus.out_valid, bus.out_data); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL skid_reopen got=%0b exp=1", bus.in_ready); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL skid_drain got=%0b exp=0", bus.out_valid); end
    total++; if (stallCnt !== 16'd2) begin bad++; $display("FAIL skid_stall_hold got=%0d exp=2", stallCnt); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = W'(32'h10);
    tick();
    bus.in_data   = W'(32'h11);
    tick();
    bus.in_data   = W'(32'hC);
    flush         = 1'b1;
    tick();
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_two_empty got=%0b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_two_ready got=%0b exp=1", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost%0d got vld=%0b data=%0h exp vld=0", i, bus.out_valid, bus.out_data); end
    end
    // Single beat popped in the flush cycle while a new beat is offered and squashed.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = W'(32'hD0);
    tick();
    bus.out_ready = 1'b1;
    bus.in_data   = W'(32'hD);
    flush         = 1'b1;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== W'(32'hD0)) begin bad++; $display("FAIL flush_pop_head got vld=%0b data=%0h exp vld=1 data=d0", bus.out_valid, bus.out_data); end
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop_push got vld=%0b data=%0h exp vld=0", bus.out_valid, bus.out_data); end
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop_late got=%0b exp=0", bus.out_valid); end
  endtask

  task automatic test_halt();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_halt   = 1'b1;
    bus.in_data   = W'(32'h5);
    tick();
    bus.in_halt   = 1'b0;
    bus.in_data   = W'(32'h66);
    total++; if (haltLock !== 1'b1) begin bad++; $display("FAIL halt_lock_set got=%0b exp=1", haltLock); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL halt_in_ready got=%0b exp=0", bus.in_ready); end
    total++; if (bus.out_data !== W'(32'h5) || bus.out_halt !== 1'b1) begin bad++; $display("FAIL halt_head got data=%0h halt=%0b exp data=5 halt=1", bus.out_data, bus.out_halt); end
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL halt_exit got=%0b exp=0", bus.out_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || haltLock !== 1'b1) begin bad++; $display("FAIL halt_closed%0d got vld=%0b rdy=%0b lock=%0b exp 0 0 1", i, bus.out_valid, bus.in_ready, haltLock); end
    end
    RST = 1'b1;
    tick();
    RST          = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (haltLock !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL halt_release got lock=%0b rdy=%0b exp 0 1", haltLock, bus.in_ready); end
  endtask

  task automatic test_saturation();
    int exp;
    busS.out_ready = 1'b0;
    busS.in_halt   = 1'b0;
    busS.in_valid  = 1'b1;
    busS.in_data   = W'(32'h99);
    tick();
    busS.in_valid  = 1'b0;
    total++; if (busS.out_valid !== 1'b1 || stallCntS !== 4'd0) begin bad++; $display("FAIL sat_start got vld=%0b cnt=%0d exp vld=1 cnt=0", busS.out_valid, stallCntS); end
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = (k < 15) ? k : 15;
      total++; if (stallCntS !== 4'(exp)) begin bad++; $display("FAIL sat_cycle%0d got=%0d exp=%0d", k, stallCntS, exp); end
    end
    total++; if (busS.out_data !== W'(32'h99)) begin bad++; $display("FAIL sat_data_stable got=%0h exp=99", busS.out_data); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_halt   = 1'b0;
    bus.in_data   = W'(32'h20);
    tick();
    bus.in_halt   = 1'b1;
    bus.in_data   = W'(32'h21);
    tick();
    bus.in_valid  = 1'b0;
    bus.in_halt   = 1'b0;
    tick();
    total++; if (stallCnt === 16'd0 || haltLock !== 1'b1) begin bad++; $display("FAIL rstmid_setup got cnt=%0d lock=%0b exp cnt>0 lock=1", stallCnt, haltLock); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%0b exp=0", bus.out_valid); end
    total++; if (stallCnt !== 16'd0) begin bad++; $display("FAIL rstmid_stall_cnt got=%0d exp=0", stallCnt); end
    total++; if (haltLock !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_lock got lock=%0b rdy=%0b exp 0 1", haltLock, bus.in_ready); end
    bus.in_valid = 1'b1;
    bus.in_data  = W'(32'h7);
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== W'(32'h7)) begin bad++; $display("FAIL rstmid_fresh got vld=%0b data=%0h exp vld=1 data=7", bus.out_valid, bus.out_data); end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_halt   = ($urandom_range(0, 39) == 0);
      bus.in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      flush         = ($urandom_range(0, 29) == 0);
      RST           = ($urandom_range(0, 199) == 0);
      if (errs < 10) begin
        total++; if (bus.in_ready !== mRdy()) begin bad++; errs++; $display("FAIL rand_in_ready c=%0d got=%0b exp=%0b", c, bus.in_ready, mRdy()); end
        total++; if (bus.out_valid !== mVld()) begin bad++; errs++; $display("FAIL rand_out_valid c=%0d got=%0b exp=%0b", c, bus.out_valid, mVld()); end
        if (mVld()) begin
          total++; if (bus.out_data !== q[0].d || bus.out_halt !== q[0].h) begin bad++; errs++; $display("FAIL rand_head c=%0d got=%0h/%0b exp=%0h/%0b", c, bus.out_data, bus.out_halt, q[0].d, q[0].h); end
        end
        total++; if (haltLock !== mLock) begin bad++; errs++; $display("FAIL rand_halt_lock c=%0d got=%0b exp=%0b", c, haltLock, mLock); end
        total++; if (int'(stallCnt) !== mStall) begin bad++; errs++; $display("FAIL rand_stall_cnt c=%0d got=%0d exp=%0d", c, stallCnt, mStall); end
      end
      tick();
    end
    RST           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_halt    = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    busS.in_valid  = 1'b0;
    busS.in_halt   = 1'b0;
    busS.in_data   = '0;
    busS.out_ready = 1'b0;
    #1;
    test_reset();
    test_streaming();
    test_skid_fill();
    test_flush();
    test_halt();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
